// File: rtl/simplerisc_pkg.sv
// rtl/simplerisc_pkg.sv - SimpleRISC opcodes, alusignals bit indices, modifier codes
package simplerisc_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_MOD  = 5'b00100;
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_OR   = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_LSL  = 5'b01010;
    localparam logic [4:0] OP_LSR  = 5'b01011;
    localparam logic [4:0] OP_ASR  = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b01101;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;
    localparam logic [4:0] OP_CSRS = 5'b11000;
    localparam logic [4:0] OP_CSRC = 5'b11001;
    localparam logic [4:0] OP_CSRR = 5'b11010;

    localparam int AS_OP_LSB  = 9;
    localparam int AS_IMM     = 8;
    localparam int AS_WB      = 7;
    localparam int AS_LD      = 6;
    localparam int AS_ST      = 5;
    localparam int AS_CALL    = 4;
    localparam int AS_CSR_RD  = 2;
    localparam int AS_CSR_SET = 1;
    localparam int AS_CSR_CLR = 0;

    localparam logic [1:0] MOD_SEXT = 2'b00;
    localparam logic [1:0] MOD_ZEXT = 2'b01;
    localparam logic [1:0] MOD_HIGH = 2'b10;

    localparam logic [3:0] RA_IDX = 4'd15;

endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - instruction handshake from fetch into the issue stage
interface alu_issue_if;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (output inst_valid, output inst, output inst_pc, input inst_ready);
    modport slave  (input inst_valid, input inst, input inst_pc, output inst_ready);
endinterface

// File: rtl/alu_issue_imm_gen.sv
// rtl/alu_issue_imm_gen.sv - immediate modifier expansion and branch offset scaling
module imm_gen
    import simplerisc_pkg::*;
(
    input  logic [15:0] imm16,
    input  logic [1:0]  modifier,
    input  logic [26:0] offset27,
    output logic [31:0] imm32,
    output logic        imm_bad,
    output logic [31:0] br_offset
);

    always_comb begin
        imm32   = 32'd0;
        imm_bad = 1'b0;
        case (modifier)
            MOD_SEXT: imm32 = {{16{imm16[15]}}, imm16};
            MOD_ZEXT: imm32 = {16'd0, imm16};
            MOD_HIGH: imm32 = {imm16, 16'd0};
            default:  imm_bad = 1'b1;
        endcase
    end

    // Word offset: sign-extend to 30 bits, then scale by 4.
    assign br_offset = {{3{offset27[26]}}, offset27, 2'b00};

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - SimpleRISC decode/issue stage with flags register and branch resolve
// Optional CSR opcodes enabled by SIMPLERISC_CSR_EN.
module alu_issue
    import simplerisc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_if.slave        inst_if,
    output logic [3:0]        rs1_addr,
    output logic [3:0]        rs2_addr,
    input  logic [31:0]       rs1_data,
    input  logic [31:0]       rs2_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [31:0]       op_a,
    output logic [31:0]       op_b,
    output logic [31:0]       op_st_data,
    output logic [3:0]        op_rd,
    output logic [13:0]       alusignals,
    input  logic [1:0]        alu_flags,
    output logic [1:0]        flags,
    output logic              branch_taken,
    output logic [31:0]       branch_target,
    output logic              illegal
);

    logic [4:0]  opc;
    logic        i_bit;
    logic [3:0]  rd_f;
    logic [31:0] imm32, br_offset;
    logic        imm_bad;

    assign opc   = inst_if.inst[31:27];
    assign i_bit = inst_if.inst[26];
    assign rd_f  = inst_if.inst[25:22];

    imm_gen u_imm_gen (
        .imm16     (inst_if.inst[15:0]),
        .modifier  (inst_if.inst[17:16]),
        .offset27  (inst_if.inst[26:0]),
        .imm32     (imm32),
        .imm_bad   (imm_bad),
        .br_offset (br_offset)
    );

    logic        dec_issue, dec_br, dec_take, dec_bad, dec_uses_imm;
    logic [13:0] dec_sig;
    logic [31:0] dec_a, dec_b, dec_target;
    logic [3:0]  dec_rd;

    always_comb begin
        dec_issue    = 1'b0;
        dec_br       = 1'b0;
        dec_take     = 1'b0;
        dec_bad      = 1'b0;
        dec_uses_imm = 1'b0;
        dec_sig      = 14'd0;
        dec_b        = i_bit ? imm32 : rs2_data;
        dec_a        = rs1_data;
        dec_rd       = rd_f;
        dec_target   = inst_if.inst_pc + br_offset;
        rs1_addr     = inst_if.inst[21:18];
        rs2_addr     = inst_if.inst[17:14];
        case (opc)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_CMP, OP_AND,
            OP_OR, OP_NOT, OP_MOV, OP_LSL, OP_LSR, OP_ASR: begin
                dec_issue              = 1'b1;
                dec_uses_imm           = i_bit;
                dec_sig[13:9]          = opc;
                dec_sig[AS_IMM]        = i_bit;
                dec_sig[AS_WB]         = (opc != OP_CMP);
                // The ALU computes ~a, so route operand B into A.
                if (opc == OP_NOT) dec_a = dec_b;
            end
            OP_NOP: ;
            OP_LD, OP_ST: begin
                dec_issue              = 1'b1;
                dec_uses_imm           = 1'b1;
                dec_b                  = imm32;
                dec_sig[13:9]          = opc;
                dec_sig[AS_IMM]        = 1'b1;
                dec_sig[AS_WB]         = (opc == OP_LD);
                dec_sig[AS_LD]         = (opc == OP_LD);
                dec_sig[AS_ST]         = (opc == OP_ST);
                if (opc == OP_ST) rs2_addr = rd_f;
            end
            OP_BEQ: begin dec_br = 1'b1; dec_take = flags[0]; end
            OP_BGT: begin dec_br = 1'b1; dec_take = flags[1]; end
            OP_B:   begin dec_br = 1'b1; dec_take = 1'b1; end
            OP_CALL: begin
                dec_br                 = 1'b1;
                dec_take               = 1'b1;
                dec_issue              = 1'b1;
                dec_b                  = inst_if.inst_pc + 32'd4;
                dec_rd                 = RA_IDX;
                dec_sig[13:9]          = OP_MOV;
                dec_sig[AS_WB]         = 1'b1;
                dec_sig[AS_CALL]       = 1'b1;
            end
            OP_RET: begin
                dec_br                 = 1'b1;
                dec_take               = 1'b1;
                rs1_addr               = RA_IDX;
                dec_target             = rs1_data;
            end
`ifdef SIMPLERISC_CSR_EN
            OP_CSRS, OP_CSRC, OP_CSRR: begin
                dec_issue              = 1'b1;
                dec_uses_imm           = i_bit;
                dec_sig[13:9]          = OP_MOV;
                dec_sig[AS_IMM]        = i_bit;
                dec_sig[AS_WB]         = 1'b1;
                dec_sig[AS_CSR_SET]    = (opc == OP_CSRS);
                dec_sig[AS_CSR_CLR]    = (opc == OP_CSRC);
                dec_sig[AS_CSR_RD]     = (opc == OP_CSRR);
            end
`endif
            default: dec_bad = 1'b1;
        endcase
        if (dec_uses_imm && imm_bad) begin
            dec_bad   = 1'b1;
            dec_issue = 1'b0;
        end
    end

    logic        op_valid_q, op_valid_d;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, op_st_data_q, op_st_data_d;
    logic [3:0]  op_rd_q, op_rd_d;
    logic [13:0] alusignals_q, alusignals_d;
    logic [1:0]  flags_q, flags_d;
    logic        branch_taken_q, branch_taken_d, illegal_q, illegal_d;
    logic [31:0] branch_target_q, branch_target_d;
    logic        flags_hazard, accept, drain;

    // A branch reading flags must wait until a pending cmp has drained.
    assign flags_hazard       = op_valid_q && (alusignals_q[13:9] == OP_CMP)
                                && ((opc == OP_BEQ) || (opc == OP_BGT));
    assign inst_if.inst_ready = (!op_valid_q || op_ready) && !flags_hazard;
    assign accept             = inst_if.inst_valid && inst_if.inst_ready;
    assign drain              = op_valid_q && op_ready;

    always_comb begin
        op_valid_d      = op_valid_q;
        op_a_d          = op_a_q;
        op_b_d          = op_b_q;
        op_st_data_d    = op_st_data_q;
        op_rd_d         = op_rd_q;
        alusignals_d    = alusignals_q;
        branch_target_d = branch_target_q;
        flags_d         = flags_q;
        branch_taken_d  = accept && dec_br && dec_take;
        illegal_d       = accept && dec_bad;
        if (drain && (alusignals_q[13:9] == OP_CMP)) flags_d = alu_flags;
        if (accept) begin
            op_valid_d = dec_issue;
            if (dec_issue) begin
                op_a_d       = dec_a;
                op_b_d       = dec_b;
                op_st_data_d = rs2_data;
                op_rd_d      = dec_rd;
                alusignals_d = dec_sig;
            end
            if (dec_br) branch_target_d = dec_target;
        end else if (op_ready) begin
            op_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_q      <= 1'b0;
            op_a_q          <= 32'd0;
            op_b_q          <= 32'd0;
            op_st_data_q    <= 32'd0;
            op_rd_q         <= 4'd0;
            alusignals_q    <= 14'd0;
            flags_q         <= 2'd0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= 32'd0;
            illegal_q       <= 1'b0;
        end else begin
            op_valid_q      <= op_valid_d;
            op_a_q          <= op_a_d;
            op_b_q          <= op_b_d;
            op_st_data_q    <= op_st_data_d;
            op_rd_q         <= op_rd_d;
            alusignals_q    <= alusignals_d;
            flags_q         <= flags_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            illegal_q       <= illegal_d;
        end
    end

    assign op_valid      = op_valid_q;
    assign op_a          = op_a_q;
    assign op_b          = op_b_q;
    assign op_st_data    = op_st_data_q;
    assign op_rd         = op_rd_q;
    assign alusignals    = alusignals_q;
    assign flags         = flags_q;
    assign branch_taken  = branch_taken_q;
    assign branch_target = branch_target_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed-vector bench for alu_issue
module tb_alu_issue;
    import simplerisc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        op_valid, op_ready;
    logic [31:0] op_a, op_b, op_st_data, branch_target;
    logic [3:0]  op_rd;
    logic [13:0] alusignals;
    logic [1:0]  alu_flags, flags;
    logic        branch_taken, illegal;
    logic [31:0] regs [16];
    int          n_vec = 0;
    int          n_err = 0;
    int          stalls;

    alu_issue_if inst_if ();

    alu_issue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_if       (inst_if.slave),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_st_data    (op_st_data),
        .op_rd         (op_rd),
        .alusignals    (alusignals),
        .alu_flags     (alu_flags),
        .flags         (flags),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(logic [4:0] op, logic [3:0] rd, logic [3:0] rs1, logic [3:0] rs2);
        return {op, 1'b0, rd, rs1, rs2, 14'd0};
    endfunction

    function automatic logic [31:0] enc_i(logic [4:0] op, logic [3:0] rd, logic [3:0] rs1, logic [1:0] md, logic [15:0] imm);
        return {op, 1'b1, rd, rs1, md, imm};
    endfunction

    function automatic logic [31:0] enc_b(logic [4:0] op, logic [26:0] off);
        return {op, off};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] pc, output int st);
        inst_if.inst_valid = 1'b1;
        inst_if.inst       = ins;
        inst_if.inst_pc    = pc;
        st = 0;
        #1;
        while (!inst_if.inst_ready && st < 20) begin
            @(negedge clk);
            #1;
            st++;
        end
        if (!inst_if.inst_ready) begin
            check({tag, "_accept_timeout"}, {31'd0, inst_if.inst_ready}, 32'd1);
            inst_if.inst_valid = 1'b0;
            @(negedge clk);
        end else begin
            @(posedge clk);
            @(negedge clk);
            inst_if.inst_valid = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'd0;
        regs[2]  = 32'd7;
        regs[3]  = 32'd5;
        regs[6]  = 32'h66;
        regs[15] = 32'h400;
        inst_if.inst_valid = 1'b0;
        inst_if.inst       = 32'd0;
        inst_if.inst_pc    = 32'd0;
        op_ready  = 1'b1;
        alu_flags = 2'b00;

        repeat (2) @(negedge clk);
        check("rst_op_valid", {31'd0, op_valid}, 32'd0);
        check("rst_alusignals", {18'd0, alusignals}, 32'd0);
        check("rst_op_b", op_b, 32'd0);
        check("rst_flags", {30'd0, flags}, 32'd0);
        check("rst_branch", {31'd0, branch_taken}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue("add", enc_r(OP_ADD, 4'd1, 4'd2, 4'd3), 32'h0, stalls);
        check("add_valid", {31'd0, op_valid}, 32'd1);
        check("add_aluop", {27'd0, alusignals[13:9]}, 32'd0);
        check("add_op_a", op_a, 32'd7);
        check("add_op_b", op_b, 32'd5);
        check("add_wb", {31'd0, alusignals[7]}, 32'd1);
        check("add_rd", {28'd0, op_rd}, 32'd1);

        issue("mov_sext", enc_i(OP_MOV, 4'd1, 4'd0, 2'b00, 16'h8001), 32'h4, stalls);
        check("mov_sext_b", op_b, 32'hFFFF8001);
        check("mov_sext_imm", {31'd0, alusignals[8]}, 32'd1);
        issue("mov_zext", enc_i(OP_MOV, 4'd1, 4'd0, 2'b01, 16'h8001), 32'h8, stalls);
        check("mov_zext_b", op_b, 32'h00008001);
        issue("mov_high", enc_i(OP_MOV, 4'd1, 4'd0, 2'b10, 16'h8001), 32'hC, stalls);
        check("mov_high_b", op_b, 32'h80010000);
        issue("mov_mod11", enc_i(OP_MOV, 4'd1, 4'd0, 2'b11, 16'h8001), 32'h10, stalls);
        check("mod11_illegal", {31'd0, illegal}, 32'd1);
        check("mod11_no_op", {31'd0, op_valid}, 32'd0);
        @(negedge clk);
        check("illegal_pulse", {31'd0, illegal}, 32'd0);

        issue("not", enc_r(OP_NOT, 4'd4, 4'd2, 4'd3), 32'h14, stalls);
        check("not_op_a", op_a, 32'd5);

        inst_if.inst = enc_i(OP_ST, 4'd6, 4'd2, 2'b00, 16'd4);
        #1 check("st_rs2_addr", {28'd0, rs2_addr}, 32'd6);
        issue("st", enc_i(OP_ST, 4'd6, 4'd2, 2'b00, 16'd4), 32'h18, stalls);
        check("st_data", op_st_data, 32'h66);
        check("st_op_b", op_b, 32'd4);
        check("st_ctl", {25'd0, alusignals[7:5]}, 32'b001);
        issue("ld", enc_i(OP_LD, 4'd7, 4'd2, 2'b00, 16'd8), 32'h1C, stalls);
        check("ld_ctl", {25'd0, alusignals[7:5]}, 32'b110);

        alu_flags = 2'b01;
        issue("cmp", enc_r(OP_CMP, 4'd0, 4'd2, 4'd3), 32'h1F0, stalls);
        check("cmp_no_wb", {31'd0, alusignals[7]}, 32'd0);
        issue("beq", enc_b(OP_BEQ, 27'd3), 32'h200, stalls);
        alu_flags = 2'b00;
        check("beq_bubble", stalls, 32'd1);
        check("beq_flags", {30'd0, flags}, 32'b01);
        check("beq_taken", {31'd0, branch_taken}, 32'd1);
        check("beq_target", branch_target, 32'h20C);
        check("beq_no_op", {31'd0, op_valid}, 32'd0);
        @(negedge clk);
        check("branch_pulse", {31'd0, branch_taken}, 32'd0);

        issue("bgt", enc_b(OP_BGT, 27'd1), 32'h300, stalls);
        check("bgt_not_taken", {31'd0, branch_taken}, 32'd0);

        issue("b_neg", enc_b(OP_B, 27'h7FFFFFE), 32'h100, stalls);
        check("b_taken", {31'd0, branch_taken}, 32'd1);
        check("b_target", branch_target, 32'hF8);

        inst_if.inst = enc_r(OP_RET, 4'd0, 4'd3, 4'd0);
        #1 check("ret_rs1_addr", {28'd0, rs1_addr}, 32'd15);
        issue("ret", enc_r(OP_RET, 4'd0, 4'd3, 4'd0), 32'h500, stalls);
        check("ret_taken", {31'd0, branch_taken}, 32'd1);
        check("ret_target", branch_target, 32'h400);

        issue("call", enc_b(OP_CALL, 27'd4), 32'h100, stalls);
        check("call_taken", {31'd0, branch_taken}, 32'd1);
        check("call_target", branch_target, 32'h110);
        check("call_valid", {31'd0, op_valid}, 32'd1);
        check("call_op_b", op_b, 32'h104);
        check("call_rd", {28'd0, op_rd}, 32'd15);
        check("call_ctl", {18'd0, alusignals}, {18'd0, OP_MOV, 9'b0_1_0_0_1_0_000});

        issue("nop", enc_r(OP_NOP, 4'd0, 4'd0, 4'd0), 32'h120, stalls);
        check("nop_no_op", {31'd0, op_valid}, 32'd0);

        op_ready = 1'b0;
        issue("stall_add", enc_r(OP_ADD, 4'd1, 4'd2, 4'd3), 32'h130, stalls);
        inst_if.inst_valid = 1'b1;
        inst_if.inst       = enc_r(OP_SUB, 4'd8, 4'd3, 4'd2);
        inst_if.inst_pc    = 32'h134;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_ready", {31'd0, inst_if.inst_ready}, 32'd0);
            check("stall_hold_valid", {31'd0, op_valid}, 32'd1);
            check("stall_hold_a", op_a, 32'd7);
            check("stall_hold_b", op_b, 32'd5);
            @(negedge clk);
        end
        op_ready = 1'b1;
        #1 check("release_ready", {31'd0, inst_if.inst_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        inst_if.inst_valid = 1'b0;
        check("release_sub_op", {27'd0, alusignals[13:9]}, {27'd0, OP_SUB});
        check("release_sub_a", op_a, 32'd5);

        issue("csrs", enc_r(OP_CSRS, 4'd2, 4'd1, 4'd0), 32'h140, stalls);
`ifdef SIMPLERISC_CSR_EN
        check("csrs_valid", {31'd0, op_valid}, 32'd1);
        check("csrs_set", {31'd0, alusignals[1]}, 32'd1);
        check("csrs_aluop", {27'd0, alusignals[13:9]}, {27'd0, OP_MOV});
`else
        check("csrs_illegal", {31'd0, illegal}, 32'd1);
        check("csrs_no_op", {31'd0, op_valid}, 32'd0);
`endif
        issue("op10101", enc_r(5'b10101, 4'd0, 4'd0, 4'd0), 32'h144, stalls);
        check("op10101_illegal", {31'd0, illegal}, 32'd1);
        check("op10101_no_op", {31'd0, op_valid}, 32'd0);

        op_ready = 1'b0;
        issue("rst_add", enc_r(OP_ADD, 4'd1, 4'd2, 4'd3), 32'h150, stalls);
        check("pre_rst_valid", {31'd0, op_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, op_valid}, 32'd0);
        check("async_rst_op_a", op_a, 32'd0);
        check("async_rst_flags", {30'd0, flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op_ready = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage for the SimpleRISC core. Accepts one 32-bit instruction per cycle from fetch over a valid/ready handshake. Decodes it into the 14-bit `alusignals` control word and ALU operands, and holds them in a single output register for the execute stage. It also owns the architectural flags register, which captures the ALU `flags` on `cmp`, and resolves `b`/`beq`/`bgt`/`call`/`ret` at issue.

## Interface
- No parameters; data width fixed at 32.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `inst_valid` in 1, `inst_ready` out 1, `inst` in 32, `inst_pc` in 32: instruction handshake from fetch.
- `rs1_addr` out 4, `rs2_addr` out 4: register-file read addresses, combinational from `inst`.
- `rs1_data` in 32, `rs2_data` in 32: register-file read data, combinational.
- `op_valid` out 1, `op_ready` in 1: handshake to execute.
- `op_a` out 32, `op_b` out 32, `op_st_data` out 32, `op_rd` out 4, `alusignals` out 14: issued operation.
- `alu_flags` in 2: ALU flags for the op currently on the output; [1] = gt, [0] = eq.
- `flags` out 2: architectural flags register.
- `branch_taken` out 1, `branch_target` out 32: registered redirect pulse to fetch.
- `illegal` out 1: registered one-cycle pulse on an undecodable opcode.

## Operation
- **Instruction fields:** opcode `inst[31:27]`, I `inst[26]`, rd `[25:22]`, rs1 `[21:18]`, rs2 `[17:14]`, modifier `[17:16]`, imm16 `[15:0]`, offset27 `[26:0]`.
- **`alusignals` layout:**
  - [13:9] ALU op, equal to the opcode for 00000–01111.
  - [8] is_imm, [7] is_wb, [6] is_ld, [5] is_st, [4] is_call, [3] always 0.
  - [2] csr_read, [1] csr_set, [0] csr_clear.
- **Immediate:** modifier 00 → sign-extend imm16; 01 → zero-extend; 10 → imm16<<16; 11 → `illegal`.
- **Operand B:** `op_b` = immediate when I=1, else `rs2_data`.
- **Operand A:** `op_a` = `rs1_data`. Exception for `not`: `op_a` = operand-B value, because the ALU computes `~a`.
- **`st`:** `rs2_addr` = rd and `op_st_data` = `rs2_data`; ALU computes rs1+imm.
- **`ld`:** rd written back; is_ld set.
- **`cmp`:** is_wb=0. On the output handshake (`op_valid && op_ready` with ALU op 00101), `flags <= alu_flags`.
- **`nop` (01101):** consumed; nothing issued.
- **`b`, `beq`, `bgt`, `ret`:** consumed without issuing an op.
  - Target for `b`/`beq`/`bgt` = `inst_pc + (sext(offset27)<<2)`; `ret` target = `rs1_data`, with `rs1_addr` forced to 15.
  - `beq` is taken iff `flags[0]`; `bgt` is taken iff `flags[1]`.
- **`call`:** redirects like `b`. Issues a `mov` (ALU op 01001) with `op_b = inst_pc+4`, rd=15, is_wb=1, is_call=1.
- **Illegal opcodes:** any opcode ≥ 10101, except enabled CSR opcodes. Consumed, no op issued, `illegal` pulses.
- **Flags hazard:** while the output register holds an un-drained `cmp`, `inst_ready`=0 for an incoming `beq`/`bgt`. This holds even if `op_ready`=1, so the branch always sees updated flags.

## Timing
- **Reset values:** `op_valid`, `alusignals`, `op_a`, `op_b`, `op_st_data`, `op_rd`, `flags`, `branch_taken`, `branch_target`, `illegal` all 0.
- **Latency:** 1 cycle from accept (`inst_valid && inst_ready`) to `op_valid`. `branch_taken`/`illegal` pulse in the cycle after accept.
- **Throughput:** `inst_ready = (!op_valid || op_ready) && !flags_hazard`. Full throughput when not stalled.
- **Stability:** outputs hold stable while `op_valid && !op_ready`.
- **Non-issuing accept:** when the accepted instruction issues nothing and the output drains in the same cycle, `op_valid` falls.
- **Flags hazard cost:** a `cmp` immediately followed by `beq` costs exactly one bubble cycle.
- **Reset mid-operation:** `rst_n` low at any time clears the registered outputs asynchronously, including a held op.

## Configuration
- **`SIMPLERISC_CSR_EN` defined:** the CSR opcodes decode as follows. All issue ALU op 01001 with is_wb=1.
  - 11000 `csrs` sets [1].
  - 11001 `csrc` sets [0].
  - 11010 `csrr` sets [2].
- **`SIMPLERISC_CSR_EN` undefined:** these opcodes are illegal, and `alusignals[2:0]` is tied to 0.

## Structure
- **Package `simplerisc_pkg`:**
  - opcode localparams;
  - `alusignals` bit-index constants;
  - modifier codes;
  - RA index 15.
- **Sub-module `imm_gen`:** combinational modifier handling and offset27 sign-extension.

## Test plan
- `add r1,r2,r3` with `rs2_data`=5 → next cycle `op_valid`=1, `alusignals[13:9]`=00000, `op_b`=5, is_wb=1.
- `mov` I=1 with imm16=0x8001 under modifiers 00/01/10 → `op_b` = 0xFFFF8001, 0x00008001, 0x80010000 respectively.
- `cmp` with `alu_flags`=01, followed back-to-back by `beq` → one bubble, then `flags`=01, `branch_taken`=1, target = pc + offset×4.
- `op_ready` held low for 3 cycles with `inst_valid`=1 → `inst_ready`=0 and outputs stable; accept resumes on release.
- `call` at pc=0x100 → `branch_taken`; issued mov has `op_b`=0x104, rd=15.
- Opcode 11000: with `SIMPLERISC_CSR_EN` → `alusignals[1]`=1; without it → `illegal` pulse and no op.
